// File: rtl/ghpi_arbiter_pkg.sv
// Shared GHPI arbiter definitions: FSM state encodings, master indices and
// the fixed byte-select presented for instruction fetches.
package ghpi_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    localparam logic MST_I = 1'b0;
    localparam logic MST_D = 1'b1;

    // Wide enough for any practical DATA_W/8; the top slices what it needs.
    localparam int unsigned          SEL_MAX_W     = 64;
    localparam logic [SEL_MAX_W-1:0] IMEM_SEL_DFLT = '1;

endpackage

// File: rtl/ghpi_arbiter_if.sv
// GHPI arbiter bus bundle: instruction master, data master and slave port.
// The arbiter takes the slave modport; the environment takes the master modport.
interface ghpi_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] imem_addr_i;
    logic              imem_valid_i;
    logic [DATA_W-1:0] imem_data_o;
    logic              imem_ack_o;

    logic [ADDR_W-1:0] dmem_addr_i;
    logic [DATA_W-1:0] dmem_data_i;
    logic [SEL_W-1:0]  dmem_sel_i;
    logic              dmem_we_i;
    logic              dmem_valid_i;
    logic [DATA_W-1:0] dmem_data_o;
    logic              dmem_ack_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [SEL_W-1:0]  mem_sel_o;
    logic              mem_we_o;
    logic              mem_valid_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  imem_addr_i, imem_valid_i,
        output imem_data_o, imem_ack_o,
        input  dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        output dmem_data_o, dmem_ack_o,
        output mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_valid_o,
        input  mem_data_i, mem_ack_i
    );

    modport master (
        output imem_addr_i, imem_valid_i,
        input  imem_data_o, imem_ack_o,
        output dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        input  dmem_data_o, dmem_ack_o,
        input  mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_valid_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/ghpi_arbiter_grant_pick.sv
// One-hot grant selection between imem and dmem. On a tie the master that did
// not complete last wins; a constant "imem last" pointer yields dmem priority.
module ghpi_grant_pick
    import ghpi_arbiter_pkg::*;
(
    input  logic       i_imem_valid,
    input  logic       i_dmem_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_imem_valid && i_dmem_valid) begin
            if (i_last == MST_D) o_grant[MST_I] = 1'b1;
            else                 o_grant[MST_D] = 1'b1;
        end else if (i_imem_valid) begin
            o_grant[MST_I] = 1'b1;
        end else if (i_dmem_valid) begin
            o_grant[MST_D] = 1'b1;
        end
    end

endmodule

// File: rtl/ghpi_arbiter.sv
// Two-master (imem/dmem) to one-slave GHPI arbiter with grant hold and watchdog.
// Define GHPI_ARB_RR_EN for round-robin tie breaking; otherwise dmem has priority.
//
// state | meaning
// IDLE  | no owner; winner routed combinationally, zero-wait ack completes here
// OWN_I | imem holds the slave until ack, abandon or watchdog abort
// OWN_D | dmem holds the slave until ack, abandon or watchdog abort
module ghpi_arbiter
    import ghpi_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ghpi_arbiter_if.slave bus,
    output logic          bus_err_o
);

    localparam int unsigned      SEL_W  = DATA_W / 8;
    localparam int unsigned      CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT);
    localparam bit               WD_EN  = (TIMEOUT != 0);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_err;
    logic              w_last;
    logic [1:0]        w_grant;
    logic              w_route_i;
    logic              w_route_d;
    logic              w_rt_i;
    logic              w_rt_d;
    logic              w_wd_hit;
    logic              w_wd_abort;
    logic              w_cnt_clr;
    logic [ADDR_W-1:0] w_addr;

`ifdef GHPI_ARB_RR_EN
    logic r_last;
    assign w_last = r_last;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                            r_last <= MST_D;
        else if (bus.mem_ack_i && (w_rt_i || w_rt_d)) r_last <= w_rt_d ? MST_D : MST_I;
    end
`else
    assign w_last = MST_I;
`endif

    ghpi_grant_pick u_pick (
        .i_imem_valid (bus.imem_valid_i),
        .i_dmem_valid (bus.dmem_valid_i),
        .i_last       (w_last),
        .o_grant      (w_grant)
    );

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_wd_hit  = WD_EN && (w_cnt_nxt == CNT_TO);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_route_i   = 1'b0;
        w_route_d   = 1'b0;
        w_wd_abort  = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_route_i = w_grant[MST_I];
                w_route_d = w_grant[MST_D];
                w_cnt_clr = 1'b1;
                if (!bus.mem_ack_i) begin
                    if (w_grant[MST_D])      w_state_nxt = OWN_D;
                    else if (w_grant[MST_I]) w_state_nxt = OWN_I;
                end
            end
            OWN_I: begin
                if (!bus.imem_valid_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_route_i = 1'b1;
                    if (bus.mem_ack_i) begin
                        w_state_nxt = IDLE;
                    end else if (w_wd_hit) begin
                        w_wd_abort  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            OWN_D: begin
                if (!bus.dmem_valid_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_route_d = 1'b1;
                    if (bus.mem_ack_i) begin
                        w_state_nxt = IDLE;
                    end else if (w_wd_hit) begin
                        w_wd_abort  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : w_cnt_nxt;
            if (w_wd_abort) r_err <= 1'b1;
        end
    end

    // Holding reset low silences every output, including the sticky error.
    assign w_rt_i = w_route_i & rst_ni;
    assign w_rt_d = w_route_d & rst_ni;
    assign w_addr = w_rt_d ? bus.dmem_addr_i : (w_rt_i ? bus.imem_addr_i : '0);

    assign bus.mem_valid_o = w_rt_i | w_rt_d;
    assign bus.mem_addr_o  = w_addr;
    assign bus.mem_data_o  = w_rt_d ? bus.dmem_data_i : '0;
    assign bus.mem_sel_o   = w_rt_d ? bus.dmem_sel_i
                           : (w_rt_i ? IMEM_SEL_DFLT[SEL_W-1:0] : '0);
    assign bus.mem_we_o    = w_rt_d & bus.dmem_we_i;

    assign bus.imem_ack_o  = w_rt_i & (bus.mem_ack_i | w_wd_abort);
    assign bus.dmem_ack_o  = w_rt_d & (bus.mem_ack_i | w_wd_abort);
    assign bus.imem_data_o = (w_rt_i && !w_wd_abort) ? bus.mem_data_i : '0;
    assign bus.dmem_data_o = (w_rt_d && !w_wd_abort) ? bus.mem_data_i : '0;

    assign bus_err_o = r_err & rst_ni;

endmodule

// File: tb/tb_ghpi_arbiter.sv
// Bench for ghpi_arbiter: master request queues, a wait-state slave model and
// a scoreboard of expected completions (master, cycle, data, routed fields).
`timescale 1ns/1ps
module tb_ghpi_arbiter;
    import ghpi_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
    localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        int          start;
    } req_t;

    typedef struct {
        logic        mst;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_err;
    int   checks = 0;
    int   errors = 0;
    int   ws = 0;
    bit   dead = 1'b0;
    int   wcnt = 0;
    req_t qi[$];
    req_t qd[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    ghpi_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ghpi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .bus_err_o (bus_err)
    );

    // Slave: acks after ws wait states of continuous valid; dead never acks.
    always @(posedge clk) begin
        if (!rst_n || !bus.mem_valid_o || bus.mem_ack_i) wcnt <= 0;
        else                                             wcnt <= wcnt + 1;
    end

    always_comb begin
        bus.mem_ack_i  = bus.mem_valid_o && !dead && (wcnt == ws);
        bus.mem_data_i = bus.mem_ack_i ? (bus.mem_addr_o ^ RD_XOR) : 32'h0;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "bench time limit");
    end

    task automatic drive_idle();
        bus.imem_addr_i  = '0;
        bus.imem_valid_i = 1'b0;
        bus.dmem_addr_i  = '0;
        bus.dmem_data_i  = '0;
        bus.dmem_sel_i   = '0;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_valid_i = 1'b0;
    endtask

    task automatic add_i(input logic [31:0] addr, input int start);
        req_t r;
        r.addr = addr; r.wdata = '0; r.sel = 4'hF; r.we = 1'b0; r.start = start;
        qi.push_back(r);
    endtask

    task automatic add_d(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic we, input int start);
        req_t r;
        r.addr = addr; r.wdata = wdata; r.sel = sel; r.we = we; r.start = start;
        qd.push_back(r);
    endtask

    task automatic exp_push(input logic mst, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input logic we, input int cyc, input bit abort);
        exp_t e;
        e.mst = mst; e.addr = addr; e.wdata = wdata; e.sel = sel; e.we = we; e.cyc = cyc;
        e.rdata = abort ? 32'h0 : (addr ^ RD_XOR);
        sb.push_back(e);
    endtask

    task automatic run_sb(input string tag, input int max_cyc);
        int          cyc;
        bit          act_i;
        bit          act_d;
        req_t        r;
        exp_t        e;
        logic        got_mst;
        logic [31:0] got_data;
        cyc = 0; act_i = 1'b0; act_d = 1'b0;
        while (sb.size() != 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (!act_i) begin
                bus.imem_valid_i = 1'b0;
                if (qi.size() != 0 && qi[0].start <= cyc) begin
                    r = qi.pop_front();
                    bus.imem_addr_i = r.addr; bus.imem_valid_i = 1'b1; act_i = 1'b1;
                end
            end
            if (!act_d) begin
                bus.dmem_valid_i = 1'b0;
                if (qd.size() != 0 && qd[0].start <= cyc) begin
                    r = qd.pop_front();
                    bus.dmem_addr_i = r.addr; bus.dmem_data_i = r.wdata;
                    bus.dmem_sel_i = r.sel; bus.dmem_we_i = r.we;
                    bus.dmem_valid_i = 1'b1; act_d = 1'b1;
                end
            end
            #2;
            checks++;
            if (bus.imem_ack_o === 1'b1 && bus.dmem_ack_o === 1'b1) begin
                errors++;
                $display("FAIL %s dual_ack cyc=%0d both acks high, required at most one", tag, cyc);
            end
            if (bus.mem_valid_o === 1'b1 && sb.size() != 0) begin
                checks++;
                if (bus.mem_addr_o !== sb[0].addr) begin
                    errors++;
                    $display("FAIL %s route_addr cyc=%0d got=%h exp=%h", tag, cyc, bus.mem_addr_o, sb[0].addr);
                end
            end
            if (bus.imem_ack_o === 1'b1 || bus.dmem_ack_o === 1'b1) begin
                got_mst  = bus.dmem_ack_o ? MST_D : MST_I;
                got_data = bus.dmem_ack_o ? bus.dmem_data_o : bus.imem_data_o;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_ack cyc=%0d master=%0d", tag, cyc, got_mst);
                end else begin
                    e = sb.pop_front();
                    if (got_mst !== e.mst) begin
                        errors++;
                        $display("FAIL %s ack_master cyc=%0d got=%0d exp=%0d", tag, cyc, got_mst, e.mst);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s ack_cycle got=%0d exp=%0d", tag, cyc, e.cyc);
                    end
                    checks++;
                    if (got_data !== e.rdata) begin
                        errors++;
                        $display("FAIL %s ack_data cyc=%0d got=%h exp=%h", tag, cyc, got_data, e.rdata);
                    end
                    checks++;
                    if ({bus.mem_we_o, bus.mem_sel_o, bus.mem_data_o} !== {e.we, e.sel, e.wdata}) begin
                        errors++;
                        $display("FAIL %s route_fields cyc=%0d got we=%b sel=%h data=%h exp we=%b sel=%h data=%h",
                                 tag, cyc, bus.mem_we_o, bus.mem_sel_o, bus.mem_data_o, e.we, e.sel, e.wdata);
                    end
                end
                if (bus.imem_ack_o === 1'b1) act_i = 1'b0;
                if (bus.dmem_ack_o === 1'b1) act_d = 1'b0;
            end
            checks++;
            if ((bus.imem_ack_o !== 1'b1 && bus.imem_data_o !== 32'h0) ||
                (bus.dmem_ack_o !== 1'b1 && bus.dmem_data_o !== 32'h0)) begin
                errors++;
                $display("FAIL %s idle_data cyc=%0d imem=%h dmem=%h exp=0", tag, cyc, bus.imem_data_o, bus.dmem_data_o);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s completion_timeout pending=%0d exp=0", tag, sb.size());
            sb.delete();
        end
        qi.delete();
        qd.delete();
        @(negedge clk);
        bus.imem_valid_i = 1'b0;
        bus.dmem_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.imem_addr_i = 32'h40; bus.imem_valid_i = 1'b1;
        bus.dmem_addr_i = 32'h80; bus.dmem_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if ((|{bus.mem_valid_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o, bus.mem_we_o,
               bus.imem_ack_o, bus.imem_data_o, bus.dmem_ack_o, bus.dmem_data_o, bus_err}) !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b addr=%h sel=%h ack_i=%b ack_d=%b err=%b exp all 0",
                     bus.mem_valid_o, bus.mem_addr_o, bus.mem_sel_o, bus.imem_ack_o, bus.dmem_ack_o, bus_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        #2;
        checks++;
        if (bus.mem_valid_o !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got valid=%b err=%b exp 0 0", bus.mem_valid_o, bus_err);
        end
    endtask

    task automatic test_tie();
        ws = 0;
        add_i(32'h100, 1);
        add_d(32'h200, 32'hCAFE_F00D, 4'b0011, 1'b1, 1);
`ifdef GHPI_ARB_RR_EN
        exp_push(MST_I, 32'h100, 32'h0, 4'hF, 1'b0, 1, 1'b0);
        exp_push(MST_D, 32'h200, 32'hCAFE_F00D, 4'b0011, 1'b1, 2, 1'b0);
`else
        exp_push(MST_D, 32'h200, 32'hCAFE_F00D, 4'b0011, 1'b1, 1, 1'b0);
        exp_push(MST_I, 32'h100, 32'h0, 4'hF, 1'b0, 2, 1'b0);
`endif
        run_sb("tie", 10);
    endtask

    task automatic test_grant_hold();
        ws = 3;
        add_i(32'h300, 1);
        add_d(32'h400, 32'h0, 4'hF, 1'b0, 2);
        exp_push(MST_I, 32'h300, 32'h0, 4'hF, 1'b0, 4, 1'b0);
        exp_push(MST_D, 32'h400, 32'h0, 4'hF, 1'b0, 8, 1'b0);
        run_sb("grant_hold", 20);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ws = 0;
        add_i(32'h10, 1); add_i(32'h14, 1); add_i(32'h18, 1);
        add_d(32'h20, 32'h1111_1111, 4'hF, 1'b1, 1);
        add_d(32'h24, 32'h0, 4'hF, 1'b0, 1);
        add_d(32'h28, 32'h0000_0022, 4'b1000, 1'b1, 1);
`ifdef GHPI_ARB_RR_EN
        exp_push(MST_I, 32'h10, 32'h0, 4'hF, 1'b0, 1, 1'b0);
        exp_push(MST_D, 32'h20, 32'h1111_1111, 4'hF, 1'b1, 2, 1'b0);
        exp_push(MST_I, 32'h14, 32'h0, 4'hF, 1'b0, 3, 1'b0);
        exp_push(MST_D, 32'h24, 32'h0, 4'hF, 1'b0, 4, 1'b0);
        exp_push(MST_I, 32'h18, 32'h0, 4'hF, 1'b0, 5, 1'b0);
        exp_push(MST_D, 32'h28, 32'h0000_0022, 4'b1000, 1'b1, 6, 1'b0);
`else
        exp_push(MST_D, 32'h20, 32'h1111_1111, 4'hF, 1'b1, 1, 1'b0);
        exp_push(MST_D, 32'h24, 32'h0, 4'hF, 1'b0, 2, 1'b0);
        exp_push(MST_D, 32'h28, 32'h0000_0022, 4'b1000, 1'b1, 3, 1'b0);
        exp_push(MST_I, 32'h10, 32'h0, 4'hF, 1'b0, 4, 1'b0);
        exp_push(MST_I, 32'h14, 32'h0, 4'hF, 1'b0, 5, 1'b0);
        exp_push(MST_I, 32'h18, 32'h0, 4'hF, 1'b0, 6, 1'b0);
`endif
        run_sb("back_to_back", 20);
    endtask

    task automatic test_timeout_boundary();
        ws = 4;
        add_d(32'h500, 32'h0, 4'hF, 1'b0, 1);
        exp_push(MST_D, 32'h500, 32'h0, 4'hF, 1'b0, 5, 1'b0);
        run_sb("ack_at_timeout", 12);
        #2;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_timeout bus_err got=%b exp=0", bus_err);
        end
    endtask

    task automatic test_watchdog();
        dead = 1'b1;
        add_i(32'h600, 1);
        exp_push(MST_I, 32'h600, 32'h0, 4'hF, 1'b0, 5, 1'b1);
        run_sb("watchdog", 12);
        dead = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #2;
            checks++;
            if (bus_err !== 1'b1 || bus.mem_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL watchdog_sticky k=%0d got err=%b valid=%b exp err=1 valid=0", k, bus_err, bus.mem_valid_o);
            end
        end
    endtask

    task automatic test_abandon();
        int n;
        bit got;
        ws = 2;
        @(negedge clk);
        bus.imem_addr_i = 32'h700; bus.imem_valid_i = 1'b1;
        #2;
        checks++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h700 || bus.imem_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abandon_grant got valid=%b addr=%h ack=%b exp 1 700 0", bus.mem_valid_o, bus.mem_addr_o, bus.imem_ack_o);
        end
        @(negedge clk);
        bus.imem_valid_i = 1'b0;
        #2;
        checks++;
        if (bus.mem_valid_o !== 1'b0 || bus.imem_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abandon_drop got valid=%b ack=%b exp 0 0", bus.mem_valid_o, bus.imem_ack_o);
        end
        @(negedge clk);
        bus.dmem_addr_i = 32'h800; bus.dmem_sel_i = 4'hF; bus.dmem_we_i = 1'b0; bus.dmem_valid_i = 1'b1;
        #2;
        checks++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h800 || bus.dmem_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL abandon_idle got valid=%b addr=%h ack=%b exp 1 800 0", bus.mem_valid_o, bus.mem_addr_o, bus.dmem_ack_o);
        end
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            #2;
            if (bus.dmem_ack_o === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != 2) begin
            errors++;
            $display("FAIL abandon_next_ack got_ack=%b after=%0d exp ack after 2", got, n);
        end
        checks++;
        if (bus.dmem_data_o !== (32'h800 ^ RD_XOR)) begin
            errors++;
            $display("FAIL abandon_next_data got=%h exp=%h", bus.dmem_data_o, 32'h800 ^ RD_XOR);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid();
        ws = 3;
        @(negedge clk);
        bus.imem_addr_i = 32'h900; bus.imem_valid_i = 1'b1;
        #2;
        checks++;
        if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h900) begin
            errors++;
            $display("FAIL reset_mid_grant got valid=%b addr=%h exp 1 900", bus.mem_valid_o, bus.mem_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ((|{bus.mem_valid_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o, bus.mem_we_o,
               bus.imem_ack_o, bus.imem_data_o, bus.dmem_ack_o, bus.dmem_data_o, bus_err}) !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got valid=%b addr=%h sel=%h ack_i=%b err=%b exp all 0",
                     bus.mem_valid_o, bus.mem_addr_o, bus.mem_sel_o, bus.imem_ack_o, bus_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #2;
            checks++;
            if (bus.imem_ack_o !== 1'b0 || bus.mem_valid_o !== 1'b0 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d got ack=%b valid=%b err=%b exp 0 0 0",
                         k, bus.imem_ack_o, bus.mem_valid_o, bus_err);
            end
        end
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_tie();
        test_grant_hold();
        test_back_to_back();
        test_timeout_boundary();
        test_watchdog();
        test_abandon();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghpi_arbiter.md
# ghpi_arbiter

Two-master to one-slave arbiter for the core's generic handshaking protocol interface (GHPI), used when the core runs Von-Neumann style against a single unified memory. It takes the core's read-only instruction port and its read/write data port and multiplexes them onto one GHPI slave port. Once a transaction is granted, the grant is held until the slave acknowledges it, so delayed (multi-cycle) transactions are supported. Zero-wait-state slaves see no added latency.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-select width is `DATA_W/8`.
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `mem_ack_i` before abort; 0 disables the watchdog.

Ports:
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `imem_addr_i` in ADDR_W: instruction-master address.
- `imem_valid_i` in 1: instruction-master request.
- `imem_data_o` out DATA_W: read data returned to the instruction master.
- `imem_ack_o` out 1: instruction-master acknowledge.
- `dmem_addr_i` in ADDR_W: data-master address, word aligned.
- `dmem_data_i` in DATA_W: data-master write data.
- `dmem_sel_i` in DATA_W/8: data-master byte select.
- `dmem_we_i` in 1: data-master write strobe.
- `dmem_valid_i` in 1: data-master request.
- `dmem_data_o` out DATA_W: read data returned to the data master.
- `dmem_ack_o` out 1: data-master acknowledge.
- `mem_addr_o` out ADDR_W, `mem_data_o` out DATA_W, `mem_sel_o` out DATA_W/8, `mem_we_o` out 1, `mem_valid_o` out 1: slave request side.
- `mem_data_i` in DATA_W, `mem_ack_i` in 1: slave response side.
- `bus_err_o` out 1: sticky flag, set by a watchdog abort.

## Operation
- FSM states: `IDLE`, `OWN_I`, `OWN_D`.
- **IDLE, arbitration:** the winner is chosen combinationally from the current valids.
  - Without `GHPI_ARB_RR_EN`, dmem wins over imem.
  - The winner's request is routed to `mem_*` in the same cycle.
- **IDLE, completion:**
  - If `mem_ack_i` is high in that cycle, the winner's ack is driven and the FSM stays in `IDLE`.
  - Otherwise the FSM moves to `OWN_I` or `OWN_D`, according to the winner.
- **OWN_x:**
  - The owner's request is routed regardless of the other master's valid.
  - On `mem_ack_i`, the owner's ack is driven and the FSM returns to `IDLE`.
  - If the owner drops valid before ack (an abandoned request), `mem_valid_o` drops that cycle and the FSM returns to `IDLE`.
- **Routing rules:**
  - imem requests are forced to `mem_we_o`=0, `mem_sel_o`=all ones, `mem_data_o`=0.
  - `x_data_o` equals `mem_data_i` when x is routed, else 0.
  - `x_ack_o` equals `mem_ack_i` and requires that x is routed.
  - When no request is routed, every `mem_*` output is 0.
- **Watchdog:**
  - A counter clears on entry to `OWN_x` and increments each cycle spent in `OWN_x`.
  - When it reaches `TIMEOUT`, the arbiter pulses the owner's ack for one cycle with data 0, sets `bus_err_o`, and returns to `IDLE`.
- **Simultaneous events:** when `mem_ack_i` arrives in the same cycle the counter reaches `TIMEOUT`, the normal ack wins and `bus_err_o` is not set.

## Timing
- **Reset** (`rst_ni`=0 at an edge):
  - FSM goes to `IDLE`; the watchdog counter clears; `bus_err_o` clears.
  - The round-robin pointer is set to "last=dmem", so imem wins the first tie.
  - While `rst_ni` is low, all outputs are forced to 0.
  - Reset mid-transaction abandons it; no ack is issued.
- **Latency:**
  - Zero added cycles: request to slave and ack to master are combinational paths.
  - A slave with N wait states gives N+1 cycles from valid to ack.
- **Back-to-back:** a new grant may be issued in the cycle immediately after an ack.
- **Handshake rules:**
  - A master must hold its address, data and valid until ack.
  - The non-routed master sees ack=0 and data=0 for as long as it waits.

## Configuration
- `GHPI_ARB_RR_EN` defined:
  - A 1-bit pointer records which master completed last.
  - On a tie in `IDLE`, the other master wins.
  - The pointer updates only on a non-timeout ack.
- `GHPI_ARB_RR_EN` undefined:
  - Fixed priority: dmem always wins a tie.
  - The pointer is not implemented.

## Structure
- Shared GHPI header holds:
  - FSM state encodings (`IDLE`=2'd0, `OWN_I`=2'd1, `OWN_D`=2'd2);
  - master index constants (`MST_I`=0, `MST_D`=1);
  - the imem default byte-select constant.
- One sub-module is natural: `ghpi_grant_pick`. Its inputs are the two valids and the pointer; its output is a one-hot grant. It contains the priority/round-robin logic only.
- The FSM, watchdog, routing muxes and error flag stay in `ghpi_arbiter`.

## Test plan
- **dmem-only tie, fixed priority:** both valid at the same cycle, addresses 0x100 (imem) and 0x200 (dmem), slave with zero wait states. Required: `mem_addr_o`=0x200 and `dmem_ack_o`=1 that cycle; imem is served the next cycle.
- **Grant hold under wait states:** imem granted to a slave with 3 wait states; dmem asserts valid during the wait. Required: `mem_addr_o` stays at the imem address for 4 cycles; dmem is served in cycle 5.
- **Round robin (`GHPI_ARB_RR_EN`):** both masters continuously valid for 6 transactions. Required: grants alternate I, D, I, D, I, D starting with imem after reset.
- **Watchdog:** `TIMEOUT`=4 and the slave never acks. Required: owner ack pulses at cycle 5 with data 0 and `bus_err_o`=1 until reset.
- **Abandon and reset:** the owner drops valid mid-wait. Required: FSM returns to `IDLE` and `mem_valid_o`=0 the same cycle. Separately, `rst_ni`=0 mid-transaction gives all outputs 0 and no ack.
